// File: rtl/ps2_lane_scorer.sv
// ps2_lane_scorer
//   This block turns the PS/2 byte stream into per-lane key state and a hit score.
//   It decodes PS/2 set-2 make, break and extended (E0) prefixes, and tracks which
//   lanes are held. A fresh press of a lane gives a one-cycle pulse and adds one to a
//   wrapping BCD score. All outputs are registered.
//
// Parameters
//   NUM_LANES    number of playable lanes (1..8)
//   LANE_CODES   packed make codes; lane i uses bits [8i+7:8i]
//   SCORE_DIGITS number of BCD score digits (1..6)
//
// Ports
//   CLOCK_50         system clock, all state on posedge
//   resetn           asynchronous active-low reset
//   ps2_key_data     received byte from PS2_Controller
//   ps2_key_pressed  one-cycle strobe qualifying ps2_key_data
//   clear            synchronous clear of score, held state and decoder
//   lane_held        bit i high while lane i key is down
//   lane_press       one-cycle pulse on a fresh press of lane i
//   score_bcd        hit count in BCD, digit 0 in [3:0]
//   score_wrap       one-cycle pulse when the score rolls from all-9s to 0
//   last_code        most recent accepted byte, prefixes included
module ps2_lane_scorer #(
    parameter int unsigned                   NUM_LANES    = 4,
    parameter logic [8*NUM_LANES-1:0]        LANE_CODES   = {8'h2B, 8'h23, 8'h1B, 8'h1C},
    parameter int unsigned                   SCORE_DIGITS = 2
) (
    input  logic                      CLOCK_50,
    input  logic                      resetn,
    input  logic [7:0]                ps2_key_data,
    input  logic                      ps2_key_pressed,
    input  logic                      clear,
    output logic [NUM_LANES-1:0]      lane_held,
    output logic [NUM_LANES-1:0]      lane_press,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic                      score_wrap,
    output logic [7:0]                last_code
);

    localparam logic [7:0] CodeBreak = 8'hF0;
    localparam logic [7:0] CodeExt   = 8'hE0;

    typedef enum logic [1:0] {
        StIdle,
        StBrk,
        StExt,
        StExtBrk
    } state_e;

    state_e state_q;

    // One-hot lane match for the current byte; the lowest index wins on duplicates.
    logic [NUM_LANES-1:0] lane_hit;
    logic                 hit_found;

    always_comb begin
        lane_hit  = '0;
        hit_found = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!hit_found && (ps2_key_data == LANE_CODES[8*i +: 8])) begin
                lane_hit[i] = 1'b1;
                hit_found   = 1'b1;
            end
        end
    end

    // BCD ripple increment: a digit advances only while every lower digit was 9.
    logic [4*SCORE_DIGITS-1:0] score_inc;
    logic                      score_carry;

    always_comb begin
        score_inc   = score_bcd;
        score_carry = 1'b1;
        for (int k = 0; k < SCORE_DIGITS; k++) begin
            if (score_carry) begin
                if (score_bcd[4*k +: 4] == 4'd9) begin
                    score_inc[4*k +: 4] = 4'd0;
                end else begin
                    score_inc[4*k +: 4] = score_bcd[4*k +: 4] + 4'd1;
                    score_carry         = 1'b0;
                end
            end
        end
    end

    // A make only counts when the matched lane was not already down (typematic repeat).
    logic fresh_press;
    assign fresh_press = |(lane_hit & ~lane_held);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            lane_held  <= '0;
            lane_press <= '0;
            score_bcd  <= '0;
            score_wrap <= 1'b0;
            last_code  <= 8'h00;
        end else if (clear) begin
            // Clear wins over a coincident strobe; that byte is dropped.
            state_q    <= StIdle;
            lane_held  <= '0;
            lane_press <= '0;
            score_bcd  <= '0;
            score_wrap <= 1'b0;
            last_code  <= 8'h00;
        end else begin
            lane_press <= '0;
            score_wrap <= 1'b0;
            if (ps2_key_pressed) begin
                last_code <= ps2_key_data;
                unique case (state_q)
                    StIdle: begin
                        if (ps2_key_data == CodeBreak) begin
                            state_q <= StBrk;
                        end else if (ps2_key_data == CodeExt) begin
                            state_q <= StExt;
                        end else begin
                            state_q <= StIdle;
                            if (fresh_press) begin
                                lane_held  <= lane_held | lane_hit;
                                lane_press <= lane_hit;
                                score_bcd  <= score_inc;
                                score_wrap <= score_carry;
                            end
                        end
                    end
                    StBrk: begin
                        // Any byte here, even F0/E0, is the break code itself.
                        lane_held <= lane_held & ~lane_hit;
                        state_q   <= StIdle;
                    end
                    StExt: begin
                        state_q <= (ps2_key_data == CodeBreak) ? StExtBrk : StIdle;
                    end
                    StExtBrk: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule
